// File: rtl/relay_pkg.sv
// Shared types and constants for the memory cycle sequencer.
package relay_pkg;

  localparam int MEM_ADDR_W = 15;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 4;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 3;
  localparam int DEF_HOLD_CYC   = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } mem_seq_state_t;

  // Counter preload for a phase lasting n clocks; the phase ends when the count reaches 0.
  function automatic logic [CNT_W-1:0] phase_load(input int n);
    return (n > 0) ? CNT_W'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 4-bit down-counter that times every phase of a memory cycle.
module phase_timer
  import relay_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mem_cycle_seq.sv
// Sequences one memory read or write cycle: setup, strobe, hold, done.
module mem_cycle_seq
  import relay_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [15:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  load_busy,
  output logic                  ack,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_wdata_oe,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = phase_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LOAD = phase_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = phase_load(HOLD_CYC);

  mem_seq_state_t   state;
  logic             cyc_we;
  logic             accept;
  logic             expired;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;

  // The CPU address space is 32K; the top address bit is deliberately dropped.
  logic unused_addr_msb;
  assign unused_addr_msb = req_addr[15];

  // ack acknowledges in the accepting IDLE clock itself, so a back-to-back
  // request sees ack exactly one clock after done; reset masks it.
  assign accept = (state == IDLE) && req && !load_busy;
  assign ack    = accept && !reset;

  // Phase counter preload, asserted on the clock that enters each timed phase.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE: if (accept) begin
        tmr_load  = 1'b1;
        tmr_value = SETUP_LOAD;
      end
      SETUP: if (expired) begin
        tmr_load  = 1'b1;
        tmr_value = STROBE_LOAD;
      end
      STROBE: if (expired && (HOLD_CYC > 0)) begin
        tmr_load  = 1'b1;
        tmr_value = HOLD_LOAD;
      end
      default: ;
    endcase
  end

  phase_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (expired)
  );

  // Cycle FSM; all memory-side outputs are registered so strobes are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register here, data included, is reset so a killed cycle leaves no stale bus value.
      state        <= IDLE;
      cyc_we       <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      mem_addr     <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state        <= SETUP;
          busy         <= 1'b1;
          cyc_we       <= req_we;
          mem_addr     <= req_addr[MEM_ADDR_W-1:0];
          mem_wdata_oe <= req_we;
          mem_wdata    <= req_we ? req_wdata : '0;
        end
        SETUP: if (expired) begin
          state     <= STROBE;
          mem_read  <= !cyc_we;
          mem_write <= cyc_we;
        end
        STROBE: if (expired) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (!cyc_we) rdata <= mem_rdata;
          if (HOLD_CYC > 0) begin
            state <= HOLD;
          end else begin
            state        <= DONE;
            done         <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wdata_oe <= 1'b0;
          end
        end
        HOLD: if (expired) begin
          state        <= DONE;
          done         <= 1'b1;
          mem_addr     <= '0;
          mem_wdata    <= '0;
          mem_wdata_oe <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_seq.sv
// Scoreboard bench for mem_cycle_seq: default-timing instance plus a 1/1/0 instance.
module tb_mem_cycle_seq;
  import relay_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // Default-timing DUT
  logic        req, req_we, load_busy;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, mem_rdata;
  logic        ack, done, busy, mem_read, mem_write, mem_wdata_oe;
  logic [7:0]  rdata, mem_wdata;
  logic [14:0] mem_addr;

  mem_cycle_seq dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_busy(load_busy), .ack(ack), .done(done),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata)
  );

  // Shortest-timing DUT
  logic        f_req, f_req_we, f_load_busy;
  logic [15:0] f_req_addr;
  logic [7:0]  f_req_wdata, f_mem_rdata;
  logic        f_ack, f_done, f_busy, f_mem_read, f_mem_write, f_mem_wdata_oe;
  logic [7:0]  f_rdata, f_mem_wdata;
  logic [14:0] f_mem_addr;

  mem_cycle_seq #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(0)) dut_fast (
    .clk(clk), .reset(reset), .req(f_req), .req_we(f_req_we), .req_addr(f_req_addr),
    .req_wdata(f_req_wdata), .load_busy(f_load_busy), .ack(f_ack), .done(f_done),
    .rdata(f_rdata), .busy(f_busy), .mem_addr(f_mem_addr), .mem_read(f_mem_read),
    .mem_write(f_mem_write), .mem_wdata(f_mem_wdata), .mem_wdata_oe(f_mem_wdata_oe),
    .mem_rdata(f_mem_rdata)
  );

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          rd_len;
    int          wr_len;
    int          oe_len;
  } exp_t;

  exp_t sb[$];
  int   ack_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: measures each cycle from ack to done and compares against the scoreboard.
  int          rd_cnt = 0, wr_cnt = 0, oe_cnt = 0;
  logic [14:0] addr_seen = '0;
  logic [7:0]  wdata_seen = '0;
  bit          overlap_seen = 1'b0;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (mem_read && mem_write) overlap_seen = 1'b1;
      if (ack) begin
        ack_q.push_back(cycle);
        rd_cnt = 0; wr_cnt = 0; oe_cnt = 0;
      end
      if (mem_read)     rd_cnt++;
      if (mem_write)    wr_cnt++;
      if (mem_wdata_oe) oe_cnt++;
      if (mem_read || mem_write) begin
        addr_seen  = mem_addr;
        wdata_seen = mem_wdata;
      end
      if (done) begin
        if (sb.size() == 0 || ack_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = sb.pop_front();
          a = ack_q.pop_front();
          check("latency",      cycle - a,          7);
          check("strobe_addr",  32'(addr_seen),     32'(e.addr));
          check("strobe_wdata", 32'(wdata_seen),    32'(e.wdata));
          check("rdata",        32'(rdata),         32'(e.rdata));
          check("read_len",     rd_cnt,             e.rd_len);
          check("write_len",    wr_cnt,             e.wr_len);
          check("oe_len",       oe_cnt,             e.oe_len);
          check("done_addr",    32'(mem_addr),      32'd0);
          check("done_oe",      32'(mem_wdata_oe),  32'd0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] mrd, input exp_t e, output int waited);
    @(posedge clk); #1;
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; mem_rdata = mrd;
    sb.push_back(e);
    waited = 0;
    @(negedge clk);
    while (!ack && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!ack) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (!done) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   waited;
    bit   bad;

    reset = 1'b1;
    req = 1'b1; req_we = 1'b0; req_addr = 16'h1111; req_wdata = 8'h00;
    load_busy = 1'b0; mem_rdata = 8'h00;
    f_req = 1'b0; f_req_we = 1'b0; f_req_addr = '0; f_req_wdata = '0;
    f_load_busy = 1'b0; f_mem_rdata = '0;

    // Reset state, with req held high to show ack is masked
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",   32'(ack),          32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_done",  32'(done),         32'd0);
    check("rst_addr",  32'(mem_addr),     32'd0);
    check("rst_strb",  32'({mem_read, mem_write, mem_wdata_oe}), 32'd0);
    check("rst_rdata", 32'(rdata),        32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Read at 8123 returning 5A
    e = '{addr: 15'h0123, wdata: 8'h00, rdata: 8'h5A, rd_len: 3, wr_len: 0, oe_len: 0};
    issue(1'b0, 16'h8123, 8'h00, 8'h5A, e, waited);
    wait_done("t1_done_timeout");

    // Write C3 to 0040; memory returns junk which must not reach rdata
    e = '{addr: 15'h0040, wdata: 8'hC3, rdata: 8'h5A, rd_len: 0, wr_len: 3, oe_len: 6};
    issue(1'b1, 16'h0040, 8'hC3, 8'hEE, e, waited);
    wait_done("t2_done_timeout");

    // Back-to-back reads with req held high
    @(posedge clk); #1;
    req = 1'b1; req_we = 1'b0; req_addr = 16'h1234; mem_rdata = 8'h11;
    e = '{addr: 15'h1234, wdata: 8'h00, rdata: 8'h11, rd_len: 3, wr_len: 0, oe_len: 0};
    sb.push_back(e);
    e = '{addr: 15'h7FFF, wdata: 8'h00, rdata: 8'h22, rd_len: 3, wr_len: 0, oe_len: 0};
    sb.push_back(e);
    waited = 0;
    @(negedge clk);
    while (!ack && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("b2b_first_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    req_addr = 16'hFFFF;
    wait_done("b2b_first_timeout");
    mem_rdata = 8'h22;
    @(negedge clk);
    check("b2b_ack_after_done", 32'(ack), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    wait_done("b2b_second_timeout");

    // load_busy blocks acceptance; rising again mid-cycle does not stop the cycle
    @(posedge clk); #1;
    load_busy = 1'b1; req = 1'b1; req_we = 1'b0; req_addr = 16'h0ABC; mem_rdata = 8'h77;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack || busy) bad = 1'b1;
    end
    check("load_busy_blocks", 32'(bad), 32'd0);
    e = '{addr: 15'h0ABC, wdata: 8'h00, rdata: 8'h77, rd_len: 3, wr_len: 0, oe_len: 0};
    sb.push_back(e);
    @(posedge clk); #1;
    load_busy = 1'b0;
    @(negedge clk);
    check("ack_after_load_busy", 32'(ack), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; load_busy = 1'b1;
    wait_done("t5_done_timeout");
    load_busy = 1'b0;

    // Reset on the second strobe clock of a write
    e = '{addr: 15'h0200, wdata: 8'h5F, rdata: 8'h77, rd_len: 0, wr_len: 3, oe_len: 6};
    issue(1'b1, 16'h0200, 8'h5F, 8'hEE, e, waited);
    waited = 0;
    @(negedge clk);
    while (!mem_write && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    @(negedge clk);
    check("pre_reset_write", 32'(mem_write), 32'd1);
    #1;
    reset = 1'b1;
    sb.delete();
    ack_q.delete();
    #1;
    check("rst_mid_write", 32'(mem_write),    32'd0);
    check("rst_mid_oe",    32'(mem_wdata_oe), 32'd0);
    check("rst_mid_busy",  32'(busy),         32'd0);
    check("rst_mid_bus",   32'({mem_addr, mem_wdata}), 32'd0);
    check("rst_mid_rdata", 32'(rdata),        32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    check("no_done_after_reset", 32'(bad), 32'd0);

    // First request after reset is taken immediately
    e = '{addr: 15'h0001, wdata: 8'h00, rdata: 8'h99, rd_len: 3, wr_len: 0, oe_len: 0};
    issue(1'b0, 16'h0001, 8'h00, 8'h99, e, waited);
    check("first_req_after_reset", waited, 0);
    wait_done("t7_done_timeout");

    // Shortest timing: SETUP 1, STROBE 1, no HOLD -> done 3 clocks after ack
    @(posedge clk); #1;
    f_req = 1'b1; f_req_we = 1'b0; f_req_addr = 16'h4321; f_mem_rdata = 8'h3C;
    @(negedge clk);
    check("fast_ack", 32'(f_ack), 32'd1);
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    check("fast_setup", 32'({f_busy, f_mem_read}), 32'b10);
    @(negedge clk);
    check("fast_strobe", 32'({f_mem_read, f_mem_addr}), 32'({1'b1, 15'h4321}));
    @(negedge clk);
    check("fast_done", 32'({f_done, f_mem_read}), 32'b10);
    check("fast_rdata", 32'(f_rdata), 32'h3C);

    repeat (3) @(negedge clk);
    check("no_strobe_overlap", 32'(overlap_seen), 32'd0);
    check("scoreboard_empty",  sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
